// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester round-robin front end for one shared
// adder/subtractor. It accepts one operation at a time, holds the ALU
// operands for ALU_WAIT cycles, captures the result and NZVC flags, and
// returns them to the owning requester with a one-cycle valid pulse.
module addsub_arbiter #(
  parameter int NBITS    = 8,
  parameter int ALU_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [NBITS-1:0] req0_x,
  input  logic [NBITS-1:0] req0_y,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [NBITS-1:0] req1_x,
  input  logic [NBITS-1:0] req1_y,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [NBITS-1:0] rsp_result,
  output logic [3:0]       rsp_nzvc,
  output logic             busy,
  output logic [NBITS-1:0] alu_x,
  output logic [NBITS-1:0] alu_y,
  output logic             alu_sub,
  input  logic [NBITS-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Counter reload: the EXEC phase lasts cnt+1 cycles, so load ALU_WAIT-1.
  localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [3:0]       cnt_q;
  logic [NBITS-1:0] alu_x_q;
  logic [NBITS-1:0] alu_y_q;
  logic             alu_sub_q;
  logic [NBITS-1:0] rsp_result_q;
  logic [3:0]       rsp_nzvc_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             busy_q;

  logic             grant_s;
  logic             grant_valid_s;
  logic             accept_s;

  // Round-robin pick: on contention favour the requester not granted last.
  always_comb begin
    grant_s       = 1'b0;
    grant_valid_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s       = ~last_grant_q;
      grant_valid_s = 1'b1;
    end else if (req0_valid) begin
      grant_s       = 1'b0;
      grant_valid_s = 1'b1;
    end else if (req1_valid) begin
      grant_s       = 1'b1;
      grant_valid_s = 1'b1;
    end else begin
      grant_s       = 1'b0;
      grant_valid_s = 1'b0;
    end
  end

  // Readies are only offered in IDLE; a granted valid is an accept.
  assign accept_s   = (state_q == IDLE) && grant_valid_s;
  assign req0_ready = accept_s && (grant_s == 1'b0);
  assign req1_ready = accept_s && (grant_s == 1'b1);

  // Sequencer: accept in IDLE, hold operands through EXEC, capture and respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_sub_q    <= 1'b0;
      rsp_result_q <= '0;
      rsp_nzvc_q   <= 4'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            alu_x_q      <= grant_s ? req1_x : req0_x;
            alu_y_q      <= grant_s ? req1_y : req0_y;
            alu_sub_q    <= grant_s ? req1_sub : req0_sub;
            owner_q      <= grant_s;
            last_grant_q <= grant_s;
            cnt_q        <= WAIT_LOAD;
            state_q      <= EXEC;
            busy_q       <= 1'b1;
          end else begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_result;
            rsp_nzvc_q   <= {alu_n, alu_z, alu_v, alu_c};
            rsp0_valid_q <= ~owner_q;
            rsp1_valid_q <= owner_q;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end else begin
            cnt_q        <= cnt_q - 4'd1;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_sub    = alu_sub_q;
  assign rsp_result = rsp_result_q;
  assign rsp_nzvc   = rsp_nzvc_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: one instance with ALU_WAIT=1 and one
// with ALU_WAIT=3, each wired to an 8-bit adder/subtractor with NZVC flags.
module tb_addsub_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  // 8-bit adder/subtractor: {result, N, Z, V, C}; subtract is x + ~y + 1.
  function automatic logic [11:0] addsub8(input logic [7:0] x, input logic [7:0] y,
                                          input logic sub);
    logic [7:0] yy;
    logic [8:0] s;
    logic [7:0] r;
    yy = sub ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + {8'd0, sub};
    r  = s[7:0];
    return {r, r[7], (r == 8'd0), (x[7] == yy[7]) && (r[7] != x[7]), s[8]};
  endfunction

  // ---------------- instance A: ALU_WAIT = 1 ----------------
  logic       a_req0_valid, a_req0_ready, a_req0_sub;
  logic [7:0] a_req0_x, a_req0_y;
  logic       a_req1_valid, a_req1_ready, a_req1_sub;
  logic [7:0] a_req1_x, a_req1_y;
  logic       a_rsp0_valid, a_rsp1_valid, a_busy, a_alu_sub;
  logic [7:0] a_rsp_result, a_alu_x, a_alu_y, a_alu_result;
  logic [3:0] a_rsp_nzvc;
  logic       a_alu_n, a_alu_z, a_alu_v, a_alu_c;

  assign {a_alu_result, a_alu_n, a_alu_z, a_alu_v, a_alu_c} = addsub8(a_alu_x, a_alu_y, a_alu_sub);

  addsub_arbiter #(.NBITS(8), .ALU_WAIT(1)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
    .req0_x(a_req0_x), .req0_y(a_req0_y), .req0_sub(a_req0_sub),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
    .req1_x(a_req1_x), .req1_y(a_req1_y), .req1_sub(a_req1_sub),
    .rsp0_valid(a_rsp0_valid), .rsp1_valid(a_rsp1_valid),
    .rsp_result(a_rsp_result), .rsp_nzvc(a_rsp_nzvc), .busy(a_busy),
    .alu_x(a_alu_x), .alu_y(a_alu_y), .alu_sub(a_alu_sub),
    .alu_result(a_alu_result), .alu_n(a_alu_n), .alu_z(a_alu_z),
    .alu_v(a_alu_v), .alu_c(a_alu_c)
  );

  // ---------------- instance B: ALU_WAIT = 3 ----------------
  logic       b_req0_valid, b_req0_ready, b_req0_sub;
  logic [7:0] b_req0_x, b_req0_y;
  logic       b_req1_valid, b_req1_ready, b_req1_sub;
  logic [7:0] b_req1_x, b_req1_y;
  logic       b_rsp0_valid, b_rsp1_valid, b_busy, b_alu_sub;
  logic [7:0] b_rsp_result, b_alu_x, b_alu_y, b_alu_result;
  logic [3:0] b_rsp_nzvc;
  logic       b_alu_n, b_alu_z, b_alu_v, b_alu_c;

  assign {b_alu_result, b_alu_n, b_alu_z, b_alu_v, b_alu_c} = addsub8(b_alu_x, b_alu_y, b_alu_sub);

  addsub_arbiter #(.NBITS(8), .ALU_WAIT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
    .req0_x(b_req0_x), .req0_y(b_req0_y), .req0_sub(b_req0_sub),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
    .req1_x(b_req1_x), .req1_y(b_req1_y), .req1_sub(b_req1_sub),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid),
    .rsp_result(b_rsp_result), .rsp_nzvc(b_rsp_nzvc), .busy(b_busy),
    .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_sub(b_alu_sub),
    .alu_result(b_alu_result), .alu_n(b_alu_n), .alu_z(b_alu_z),
    .alu_v(b_alu_v), .alu_c(b_alu_c)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one full cycle; inputs are driven and outputs sampled at negedge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Solo operation on instance A (ALU_WAIT=1) with hand-computed result.
  task automatic solo_op(input string tag, input logic who, input logic [7:0] x,
                         input logic [7:0] y, input logic sub,
                         input logic [7:0] exp_res, input logic [3:0] exp_nzvc);
    if (who) begin
      a_req1_valid = 1'b1; a_req1_x = x; a_req1_y = y; a_req1_sub = sub;
    end else begin
      a_req0_valid = 1'b1; a_req0_x = x; a_req0_y = y; a_req0_sub = sub;
    end
    #1;
    check({tag, " req0_ready"}, int'(a_req0_ready), int'(!who));
    check({tag, " req1_ready"}, int'(a_req1_ready), int'(who));
    next_cycle();
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    #1;
    check({tag, " busy"}, int'(a_busy), 1);
    check({tag, " alu_x"}, int'(a_alu_x), int'(x));
    next_cycle();
    #1;
    check({tag, " rsp0_valid"}, int'(a_rsp0_valid), int'(!who));
    check({tag, " rsp1_valid"}, int'(a_rsp1_valid), int'(who));
    check({tag, " result"}, int'(a_rsp_result), int'(exp_res));
    check({tag, " nzvc"}, int'(a_rsp_nzvc), int'(exp_nzvc));
    check({tag, " busy_done"}, int'(a_busy), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    a_req0_valid = 1'b0; a_req0_x = 8'h00; a_req0_y = 8'h00; a_req0_sub = 1'b0;
    a_req1_valid = 1'b0; a_req1_x = 8'h00; a_req1_y = 8'h00; a_req1_sub = 1'b0;
    b_req0_valid = 1'b0; b_req0_x = 8'h00; b_req0_y = 8'h00; b_req0_sub = 1'b0;
    b_req1_valid = 1'b0; b_req1_x = 8'h00; b_req1_y = 8'h00; b_req1_sub = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst busy", int'(a_busy), 0);
    check("rst alu_x", int'(a_alu_x), 0);
    check("rst alu_y", int'(a_alu_y), 0);
    check("rst result", int'(a_rsp_result), 0);
    check("rst nzvc", int'(a_rsp_nzvc), 0);
    check("rst rsp0", int'(a_rsp0_valid), 0);
    check("rst rsp1", int'(a_rsp1_valid), 0);
    reset = 1'b0;
    next_cycle();

    // Solo operations
    solo_op("add7F01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010);
    next_cycle();
    #1;
    check("add7F01 pulse_end", int'(a_rsp0_valid), 0);
    check("add7F01 hold", int'(a_rsp_result), 8'h80);
    solo_op("sub0001", 1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000);
    solo_op("sub0505", 1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0101);

    // Contention: both valid continuously for six operations (last_grant=1)
    a_req0_valid = 1'b1; a_req0_x = 8'h80; a_req0_y = 8'h80; a_req0_sub = 1'b0;
    a_req1_valid = 1'b1; a_req1_x = 8'hFF; a_req1_y = 8'h01; a_req1_sub = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cont%0d req0_ready", i), int'(a_req0_ready), int'((i % 2) == 0));
      check($sformatf("cont%0d req1_ready", i), int'(a_req1_ready), int'((i % 2) == 1));
      if (i > 0) begin
        check($sformatf("cont%0d prev rsp0", i), int'(a_rsp0_valid), int'((i % 2) == 1));
        check($sformatf("cont%0d prev rsp1", i), int'(a_rsp1_valid), int'((i % 2) == 0));
        check($sformatf("cont%0d prev nzvc", i), int'(a_rsp_nzvc),
              ((i % 2) == 1) ? 4'b0111 : 4'b0101);
        check($sformatf("cont%0d prev result", i), int'(a_rsp_result), 0);
      end
      next_cycle();
      #1;
      check($sformatf("cont%0d busy", i), int'(a_busy), 1);
      check($sformatf("cont%0d ready_exec", i), int'(a_req0_ready | a_req1_ready), 0);
      next_cycle();
    end
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    #1;
    check("cont last rsp1", int'(a_rsp1_valid), 1);
    check("cont last rsp0", int'(a_rsp0_valid), 0);
    check("cont last nzvc", int'(a_rsp_nzvc), 4'b0101);
    next_cycle();

    // Withdraw: req1 raised while busy, dropped before it can be granted
    a_req0_valid = 1'b1; a_req0_x = 8'h10; a_req0_y = 8'h20; a_req0_sub = 1'b0;
    next_cycle();
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b1; a_req1_x = 8'h33; a_req1_y = 8'h11; a_req1_sub = 1'b1;
    #1;
    check("wd req1_ready busy", int'(a_req1_ready), 0);
    next_cycle();
    a_req1_valid = 1'b0;
    #1;
    check("wd rsp0", int'(a_rsp0_valid), 1);
    check("wd result", int'(a_rsp_result), 8'h30);
    check("wd req1_ready", int'(a_req1_ready), 0);
    next_cycle();
    #1;
    check("wd no rsp1", int'(a_rsp1_valid), 0);
    check("wd idle", int'(a_busy), 0);
    // last_grant is still 0, so a contended grant must go to requester 1
    a_req0_valid = 1'b1; a_req0_x = 8'h80; a_req0_y = 8'h80; a_req0_sub = 1'b0;
    a_req1_valid = 1'b1; a_req1_x = 8'hFF; a_req1_y = 8'h01; a_req1_sub = 1'b0;
    #1;
    check("wd grant req1", int'(a_req1_ready), 1);
    check("wd grant req0", int'(a_req0_ready), 0);
    next_cycle();
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    next_cycle();
    #1;
    check("wd op rsp1", int'(a_rsp1_valid), 1);
    check("wd op nzvc", int'(a_rsp_nzvc), 4'b0101);
    next_cycle();

    // Reset in the middle of EXEC
    a_req0_valid = 1'b1; a_req0_x = 8'h7F; a_req0_y = 8'h01; a_req0_sub = 1'b0;
    next_cycle();
    a_req0_valid = 1'b0;
    #1;
    check("mid busy before", int'(a_busy), 1);
    reset = 1'b1;
    #1;
    check("mid rst busy", int'(a_busy), 0);
    check("mid rst alu_x", int'(a_alu_x), 0);
    check("mid rst nzvc", int'(a_rsp_nzvc), 0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("mid no rsp0", int'(a_rsp0_valid), 0);
    next_cycle();
    #1;
    check("mid no rsp0 later", int'(a_rsp0_valid), 0);
    check("mid no rsp1 later", int'(a_rsp1_valid), 0);
    a_req0_valid = 1'b1; a_req0_x = 8'h80; a_req0_y = 8'h80; a_req0_sub = 1'b0;
    a_req1_valid = 1'b1; a_req1_x = 8'hFF; a_req1_y = 8'h01; a_req1_sub = 1'b0;
    #1;
    check("post rst grant req0", int'(a_req0_ready), 1);
    check("post rst grant req1", int'(a_req1_ready), 0);
    next_cycle();
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    next_cycle();
    #1;
    check("post rst rsp0", int'(a_rsp0_valid), 1);
    check("post rst nzvc", int'(a_rsp_nzvc), 4'b0111);

    // ALU_WAIT = 3 on instance B: 12 + 34 = 46, flags 0000
    b_req0_valid = 1'b1; b_req0_x = 8'h12; b_req0_y = 8'h34; b_req0_sub = 1'b0;
    #1;
    check("w3 req0_ready", int'(b_req0_ready), 1);
    next_cycle();
    b_req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("w3 busy%0d", k), int'(b_busy), 1);
      check($sformatf("w3 alu_x%0d", k), int'(b_alu_x), 8'h12);
      check($sformatf("w3 alu_y%0d", k), int'(b_alu_y), 8'h34);
      check($sformatf("w3 rsp0_%0d", k), int'(b_rsp0_valid), 0);
      next_cycle();
    end
    #1;
    check("w3 busy done", int'(b_busy), 0);
    check("w3 rsp0", int'(b_rsp0_valid), 1);
    check("w3 rsp1", int'(b_rsp1_valid), 0);
    check("w3 result", int'(b_rsp_result), 8'h46);
    check("w3 nzvc", int'(b_rsp_nzvc), 4'b0000);
    next_cycle();
    #1;
    check("w3 pulse end", int'(b_rsp0_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one 8-bit adder/subtractor (AddSub8Bit datapath) between two clients.
- Accepts an operation (x, y, sub) from one requester at a time and drives registered operands onto the shared ALU.
- Waits a programmable settle time, then captures the result and NZVC flags into registers.
- Returns the result to the owning requester with a one-cycle valid pulse.

Parameters:
- NBITS, 8: operand/result width; must match the attached ALU.
- ALU_WAIT, 1: number of EXEC cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_x  input  NBITS  requester 0 operand x.
- req0_y  input  NBITS  requester 0 operand y.
- req0_sub  input  1  requester 0 op: 1 = x-y, 0 = x+y.
- req1_valid  input  1  as req0_valid, for requester 1.
- req1_ready  output  1  as req0_ready, for requester 1.
- req1_x  input  NBITS  as req0_x, for requester 1.
- req1_y  input  NBITS  as req0_y, for requester 1.
- req1_sub  input  1  as req0_sub, for requester 1.
- rsp0_valid  output  1  one-cycle pulse: rsp_result/rsp_nzvc belong to requester 0.
- rsp1_valid  output  1  one-cycle pulse: rsp_result/rsp_nzvc belong to requester 1.
- rsp_result  output  NBITS  captured ALU result, shared by both requesters.
- rsp_nzvc  output  4  captured flags {N,Z,V,C}.
- busy  output  1  high while in EXEC.
- alu_x  output  NBITS  registered operand to the ALU.
- alu_y  output  NBITS  registered operand to the ALU.
- alu_sub  output  1  registered op select to the ALU.
- alu_result  input  NBITS  ALU result.
- alu_n, alu_z, alu_v, alu_c  input  1 each  ALU flags.

Behaviour:
- Reset (asynchronous, active-high), effective immediately and held until deassertion:
  - state=IDLE, last_grant=1, wait counter=0.
  - alu_x=0, alu_y=0, alu_sub=0, rsp_result=0, rsp_nzvc=0.
  - rsp0_valid=0, rsp1_valid=0, busy=0.
- Reset mid-EXEC aborts the operation: no response is issued and the request is lost; the requester must re-issue it.
- States: IDLE, EXEC.
- IDLE grant (combinational):
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high in any cycle.
  - Ready may depend combinationally on valid; requesters must not make valid depend on ready.
- Accept (edge where reqN_valid && reqN_ready):
  - Latch alu_x/alu_y/alu_sub from requester N, record owner=N, last_grant=N.
  - Load the wait counter with ALU_WAIT-1 and go to EXEC.
- EXEC:
  - busy=1; both readys are 0.
  - alu_x/alu_y/alu_sub are held stable.
  - Counter decrements each cycle. On the edge where counter==0: capture rsp_result=alu_result and rsp_nzvc={alu_n,alu_z,alu_v,alu_c}, set rsp<owner>_valid=1, go to IDLE.
- Response:
  - rspN_valid is high for exactly one cycle, with no backpressure.
  - rsp_result/rsp_nzvc hold their value until the next capture.
  - The other rsp valid stays 0.
- Latency: accept at edge E0, capture at edge E(ALU_WAIT), response valid during the cycle after E(ALU_WAIT). With ALU_WAIT=1: accept edge 0, rsp valid in cycle 1.
- Throughput: a new accept may occur in the same cycle rsp valid is high, because the block is already in IDLE. Peak rate is one operation per ALU_WAIT+1 cycles.
- Requester rules:
  - reqN_x/y/sub must stay stable while reqN_valid is high and not yet accepted.
  - Dropping valid before acceptance withdraws the request with no side effect.
- Fairness: under continuous requests from both requesters, grants strictly alternate. After reset, the first contended grant goes to requester 0.
- Widths: the block performs no arithmetic on operands; values pass through unchanged. The counter is 4 bits.

Test Plan:
- Bench instantiates the real 8-bit adder/subtractor as the ALU, with NBITS=8 and ALU_WAIT=1.
- Solo add: req0 x=7F, y=01, sub=0 → req0_ready same cycle; rsp0_valid one cycle later; rsp_result=80, nzvc=1010; rsp1_valid stays 0.
- Solo sub: req1 x=00, y=01, sub=1 → rsp1_valid; result=FF, nzvc=1000. Then req1 x=05, y=05, sub=1 → result=00, nzvc=0101.
- Contention: both valid continuously for 6 operations (req0 80+80, req1 FF+01) → grants alternate 0,1,0,1,0,1.
  - req0 responses: result=00, nzvc=0111.
  - req1 responses: result=00, nzvc=0101.
  - One accept every 2 cycles.
- ALU_WAIT=3: single request → alu_x/alu_y stable for 3 EXEC cycles; busy high for 3 cycles; rsp valid on the 4th cycle after accept.
- Reset during EXEC: assert reset asynchronously in the EXEC cycle → busy, alu_x and rsp_nzvc go to 0 immediately; no rsp valid pulse; after release, req1 and req0 both valid → req0 granted first.
- Withdraw: req1 valid for one cycle while busy, then dropped → no grant to requester 1, no response, last_grant unchanged.
